multi_tick_gen: RTL
===================

// Module: multi_tick_gen
// PURPOSE
//  Parametrised multi-channel tick/clock-enable generator; successor of the fixed /4 and
//  /CYCLES dividers. NCH independent channels, each with runtime-programmable divide
//  ratio and mode: single-cycle strobe (PULSE) or 50% square wave (TOGGLE).
//  Feeds VGA pixel enables, blink/flash timers and sprite animation rates from one clk.
// PARAMETERS
//  NCH      4           number of channels (1..16)
//  CW       32          divide-ratio / counter width
//  DEF_DIV  4           divide ratio loaded into every channel at reset
//  DEF_MODE 0           mode loaded at reset (0 = PULSE, 1 = TOGGLE)
// PORTS
//  clk        in   1             system clock
//  reset      in   1             asynchronous, active-high reset
//  enable     in   NCH           per-channel count enable; bit i gates channel i
//  cfg_valid  in   1             config request valid
//  cfg_ready  out  1             config slot for cfg_ch free (combinational)
//  cfg_ch     in   $clog2(NCH)   target channel (max(1,..) bits when NCH=1)
//  cfg_div    in   CW            new divide ratio; 0 = channel parked
//  cfg_mode   in   1             new mode
//  tick       out  NCH           per-channel output (registered)
//  wrapped    out  NCH           1-cycle strobe at each terminal count (both modes)
// BEHAVIOUR
//  Reset (async, any time): cnt=0, div=DEF_DIV, mode=DEF_MODE, pending=0, tick=0, wrapped=0.
//  Per channel, each posedge with enable[i]=1 and div!=0:
//   - cnt counts 0..div-1. At cnt==div-1: cnt<=0, wrapped<=1; PULSE: tick<=1;
//     TOGGLE: tick<=~tick. Otherwise cnt<=cnt+1, wrapped<=0, PULSE tick<=0.
//   - Result: PULSE = 1-cycle high every div cycles; TOGGLE period = 2*div.
//   - First event is div edges after enable rises with cnt=0 (div=4: 4th edge).
//   - div=1: PULSE tick held high; TOGGLE toggles every cycle.
//  enable[i]=0: cnt and TOGGLE level hold; PULSE tick and wrapped forced 0 next edge.
//  div==0 (parked): cnt<=0, tick<=0, wrapped<=0 regardless of enable.
//  Config handshake: transfer when cfg_valid && cfg_ready; cfg_ready = ~pending[cfg_ch].
//   - Accepted div/mode go to a per-channel shadow, pending<=1.
//   - Shadow commits (div,mode <= shadow; cnt<=0; pending<=0) on the same edge as the
//     channel's next terminal count -> no runt pulses or short half-periods.
//   - Commits immediately (next edge) if enable[i]=0 or current div==0.
//   - On commit with a mode change, tick<=0. Same-mode commit keeps the TOGGLE level.
//   - Second request to a pending channel stalls (cfg_ready=0) until commit edge+1.
//   - Terminal count and commit on same edge: the terminal event (tick/wrapped) is
//     produced with the old settings; the new settings apply from the next cycle.
//  Counter arithmetic unsigned, width CW; compare uses div-1 (div!=0 guaranteed there).
//  Channels fully independent; no cross-channel phase alignment.
// STRUCTURE
//  Include multi_tick_defs.vh: MODE_PULSE=1'b0, MODE_TOGGLE=1'b1, DEF_DIV/DEF_MODE defaults.
//  Sub-module multi_tick_chan (one channel: cnt, div/mode regs, shadow, pending, outputs),
//  instantiated NCH times via generate; top holds cfg_ch decode and the cfg_ready mux.
// TESTING
//  1 Reset, enable=all 1, defaults -> every tick high 1 cycle of 4; first at 4th edge.
//  2 cfg ch1 div=3 TOGGLE while running -> commit at ch1 terminal; then tick period 6,
//    duty 3/3; no pulse shorter than 3 cycles across the switch.
//  3 cfg ch2 twice back-to-back -> cfg_ready low after first accept until its commit;
//    second value applied only at the following terminal count.
//  4 div=1 PULSE -> tick constant 1; div=0 -> tick,wrapped 0 within 1 cycle, cnt 0.
//  5 enable[0] dropped mid-count (cnt=2, div=4), raised 5 cycles later -> next tick
//    2 edges after re-enable; PULSE tick 0 while disabled.
//  6 reset asserted mid-period and mid-pending -> all outputs 0 asynchronously,
//    pending cleared, channels resume with DEF_DIV/DEF_MODE after release.

Source files
------------

// File: rtl/multi_tick_pkg.sv
// -----------------------------------------------------------------------------
// multi_tick_pkg
// Shared definitions for the multi-channel tick generator: mode encodings,
// reset defaults and the channel-select width helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package multi_tick_pkg;

   localparam logic MODE_PULSE  = 1'b0;
   localparam logic MODE_TOGGLE = 1'b1;

   localparam int   DEF_DIV_DFLT  = 4;
   localparam logic DEF_MODE_DFLT = MODE_PULSE;

   // Channel-select width; a single-channel build still gets a 1-bit select.
   function automatic int ch_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_tick_chan.sv
// -----------------------------------------------------------------------------
// multi_tick_chan
// One tick channel: counter, active divide/mode, shadow divide/mode with a
// pending flag, and registered tick/wrapped outputs.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   enable       count enable for this channel
//   load         accepted config request for this channel (only when !pending)
//   load_div     requested divide ratio (0 = parked)
//   load_mode    requested mode
//   pending      shadow holds an uncommitted request
//   tick         channel output (strobe or square wave)
//   wrapped      1-cycle strobe on each terminal count
// -----------------------------------------------------------------------------
module multi_tick_chan
   import multi_tick_pkg::*;
#(
   parameter int   CW       = 32,
   parameter int   DEF_DIV  = DEF_DIV_DFLT,
   parameter logic DEF_MODE = DEF_MODE_DFLT
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          load,
   input  logic [CW-1:0] load_div,
   input  logic          load_mode,
   output logic          pending,
   output logic          tick,
   output logic          wrapped
);

   logic [CW-1:0] cnt, div, sdiv;
   logic          mode, smode;

   logic [CW-1:0] cnt_n, div_n;
   logic          mode_n, pend_n, tick_n, wrap_n;
   logic          parked, terminal, commit;

   always_comb begin
      cnt_n  = cnt;
      div_n  = div;
      mode_n = mode;
      pend_n = pending;
      tick_n = tick;
      wrap_n = 1'b0;

      parked   = (div == '0);
      // div-1 is only meaningful when not parked, hence the guard.
      terminal = enable && !parked && (cnt == div - CW'(1));
      // Commit on the terminal edge so the running period always completes;
      // a stopped or parked channel has no period to protect.
      commit   = pending && (terminal || !enable || parked);

      if (parked) begin
         cnt_n  = '0;
         tick_n = 1'b0;
      end else if (!enable) begin
         if (mode == MODE_PULSE) tick_n = 1'b0;
      end else if (terminal) begin
         cnt_n  = '0;
         wrap_n = 1'b1;
         tick_n = (mode == MODE_PULSE) ? 1'b1 : ~tick;
      end else begin
         cnt_n = cnt + CW'(1);
         if (mode == MODE_PULSE) tick_n = 1'b0;
      end

      if (commit) begin
         div_n  = sdiv;
         mode_n = smode;
         cnt_n  = '0;
         pend_n = 1'b0;
         // On a terminal edge the old-mode event stands; the new mode starts
         // from that level on the next cycle.
         if (!terminal && (smode != mode)) tick_n = 1'b0;
      end

      if (load) pend_n = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         div     <= CW'(DEF_DIV);
         mode    <= DEF_MODE;
         pending <= 1'b0;
         tick    <= 1'b0;
         wrapped <= 1'b0;
      end else begin
         cnt     <= cnt_n;
         div     <= div_n;
         mode    <= mode_n;
         pending <= pend_n;
         tick    <= tick_n;
         wrapped <= wrap_n;
      end
   end

   // Shadow contents are only consumed while pending is set, so no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         sdiv  <= load_div;
         smode <= load_mode;
      end
   end

endmodule

// File: rtl/multi_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_tick_gen
// NCH independent tick / clock-enable channels, each with a runtime
// programmable divide ratio and PULSE or TOGGLE mode.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   enable     per-channel count enable
//   cfg_valid  config request valid
//   cfg_ready  config slot of cfg_ch free (combinational)
//   cfg_ch     target channel
//   cfg_div    new divide ratio (0 = channel parked)
//   cfg_mode   new mode (0 = PULSE, 1 = TOGGLE)
//   tick       per-channel registered output
//   wrapped    per-channel terminal-count strobe
// -----------------------------------------------------------------------------
module multi_tick_gen
   import multi_tick_pkg::*;
#(
   parameter  int   NCH      = 4,
   parameter  int   CW       = 32,
   parameter  int   DEF_DIV  = DEF_DIV_DFLT,
   parameter  logic DEF_MODE = DEF_MODE_DFLT,
   localparam int   CHW      = ch_bits(NCH)
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] enable,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   input  logic           cfg_mode,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] wrapped
);

   logic [NCH-1:0] pending;
   logic [NCH-1:0] load;

   // An out-of-range channel select never reports ready.
   always_comb begin
      cfg_ready = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CHW'(i)) cfg_ready = ~pending[i];
      end
   end

   always_comb begin
      load = '0;
      for (int i = 0; i < NCH; i++) begin
         load[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      multi_tick_chan #(
         .CW       (CW),
         .DEF_DIV  (DEF_DIV),
         .DEF_MODE (DEF_MODE)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .enable    (enable[g]),
         .load      (load[g]),
         .load_div  (cfg_div),
         .load_mode (cfg_mode),
         .pending   (pending[g]),
         .tick      (tick[g]),
         .wrapped   (wrapped[g])
      );
   end

endmodule
